pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Front-end controller that sits directly upstream of the pipelined core.
- Owns the architectural PC register: drives the core's pc input and consumes its next-PC and exception outputs each cycle.
- Sequences core reset, run, drain and halt. Records the trap cause and the PC at the trap.
- Provides a cycle counter and a fetch-progress watchdog.

Parameters:
- DATA_WIDTH, 64, PC/data width (matches the pipeline package).
- RESET_PC, 64'h0, PC loaded on reset.
- CORE_RST_CYCLES, 2, cycles core_rst_o is held high after reset before IDLE (min 1).
- DRAIN_CYCLES, 3, cycles the core keeps running after a trap before being held in reset (min 1).
- WDOG_CYCLES, 1024, consecutive no-progress RUN cycles that fire the watchdog (min 2).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- new_pc_i  in  DATA_WIDTH  next PC from core
- exceptions_i  in  8  registered exception vector from core; bits 0..4 = fetch, decode, mem-access, ecall, ebreak
- run_i  in  1  start/resume request
- halt_req_i  in  1  external halt request
- pc_load_i  in  1  load PC (honoured in IDLE/HALT only)
- pc_load_val_i  in  DATA_WIDTH  value for pc_load_i
- pc_o  out  DATA_WIDTH  PC to core
- core_rst_o  out  1  active-high reset to core
- state_o  out  2  0=RESET 1=IDLE 2=RUN/DRAIN 3=HALT
- halted_o  out  1  high in HALT
- cause_o  out  8  sticky trap cause: bits 4:0 exceptions, bit5 halt_req, bit7 watchdog, bit6 reserved 0
- trap_pc_o  out  DATA_WIDTH  pc_o value in the cycle the trap was captured
- cycle_cnt_o  out  64  cycles spent in RUN, wraps modulo 2^64

Behaviour:
- Reset (rst_ni=0 at posedge) applies in any state, including mid-DRAIN. Next-cycle values:
  - state RESET, pc_o=RESET_PC, core_rst_o=1, halted_o=0, cause_o=0, trap_pc_o=0, cycle_cnt_o=0.
  - Internal drain and watchdog counters cleared.
- RESET:
  - core_rst_o=1.
  - Stays exactly CORE_RST_CYCLES cycles, then IDLE.
  - run_i, halt_req_i and pc_load_i are ignored.
- IDLE / HALT:
  - core_rst_o=1; pc_o holds.
  - pc_load_i=1 sets pc_o=pc_load_val_i next cycle.
  - run_i=1 enters RUN next cycle. If pc_load_i and run_i are both high, the load takes effect and RUN starts from the loaded PC.
  - Entering RUN from HALT clears cause_o; trap_pc_o keeps its last value.
  - exceptions_i is ignored.
- RUN:
  - core_rst_o=0; pc_o<=new_pc_i every cycle; cycle_cnt_o increments.
  - Trap capture, evaluated each cycle:
    - (exceptions_i[4:0]!=0) or halt_req_i or watchdog fire → cause_o <= {wdog,0,halt_req_i,exceptions_i[4:0]}.
    - trap_pc_o<=pc_o; enter DRAIN.
    - Simultaneous sources OR together; there is no priority among cause bits.
    - pc_o still takes new_pc_i on the capture cycle.
  - Watchdog:
    - Counter increments when new_pc_i==pc_o; clears when it differs.
    - Fires when the counter reaches WDOG_CYCLES-1 while still equal, i.e. on the WDOG_CYCLES-th consecutive stalled cycle.
    - Counter clears on leaving RUN.
- DRAIN:
  - core_rst_o=0; pc_o frozen at its value after capture.
  - Lasts exactly DRAIN_CYCLES cycles, then HALT.
  - Further exceptions_i and halt_req_i are ignored; cause_o is frozen.
  - cycle_cnt_o does not increment.
  - state_o=2.
- HALT: halted_o=1 (registered, coincident with state).
- Arithmetic:
  - Counters are unsigned and wrap.
  - Drain and watchdog counters are $clog2-sized from their parameters.
  - A PC comparison is full DATA_WIDTH equality.

Decomposition:
- Shared pipeline package:
  - the seq_state_e enum;
  - cause bit index constants (CAUSE_FETCH..CAUSE_EBREAK=0..4, CAUSE_HALT=5, CAUSE_WDOG=7), aligned with the core's exception bit order;
  - DATA_WIDTH.
- One sub-module: pc_watchdog (compare, counter, fire pulse; inputs enable/clear).

Test Plan:
- Reset, then release: core_rst_o=1 for exactly 2 cycles, pc_o=0, state_o=1. Then run_i pulse; new_pc_i = pc+4 → pc_o sequence 0,4,8; cycle_cnt_o=3 after 3 RUN cycles.
- In RUN at pc_o=0x40, exceptions_i=8'h08 (ecall) for one cycle:
  - cause_o=0x08, trap_pc_o=0x40;
  - 3 DRAIN cycles with pc_o frozen and core_rst_o=0;
  - then HALT, halted_o=1, core_rst_o=1.
- Simultaneous exceptions_i=8'h02 and halt_req_i=1 → cause_o=0x22. An ebreak arriving during DRAIN leaves cause_o at 0x22.
- WDOG_CYCLES=8 and new_pc_i held equal to pc_o=0x100:
  - trap on the 8th stalled cycle, cause_o=0x80, trap_pc_o=0x100;
  - a one-cycle progress at cycle 5 restarts the count.
- In HALT: pc_load_i with 0x200 plus run_i in the same cycle → RUN from pc_o=0x200, cause_o=0.
- rst_ni=0 during DRAIN → next cycle RESET, all outputs at reset values, no entry to HALT.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared pipeline constants: datapath width, sequencer state encoding, trap cause bit map.
// Cause bits 0..4 follow the core's exception vector order so they can be copied straight across.
package pc_sequencer_pkg;

  localparam int DATA_WIDTH = 64;

  typedef enum logic [1:0] {
    SEQ_RESET = 2'd0,
    SEQ_IDLE  = 2'd1,
    SEQ_RUN   = 2'd2,
    SEQ_HALT  = 2'd3
  } seq_state_e;

  localparam int CAUSE_FETCH  = 0;
  localparam int CAUSE_DECODE = 1;
  localparam int CAUSE_MEM    = 2;
  localparam int CAUSE_ECALL  = 3;
  localparam int CAUSE_EBREAK = 4;
  localparam int CAUSE_HALT   = 5;
  localparam int CAUSE_WDOG   = 7;

  // Counter width for a count of n; never below one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pc_watchdog.sv
// Fetch-progress watchdog: counts consecutive cycles where the core returns the same PC.
// Latency: fire_o is combinational on the WDOG_CYCLES-th stalled cycle; no backpressure.
module pc_watchdog #(
  parameter int DATA_WIDTH  = 64,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] new_pc_i,
  output logic                  fire_o
);
  import pc_sequencer_pkg::*;

  localparam int            CW   = cnt_width(WDOG_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(WDOG_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic          stall;

  assign stall  = (new_pc_i == pc_i);
  assign fire_o = en_i && stall && (cnt_q == LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= stall ? cnt_q + CW'(1) : '0;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Front-end controller owning the architectural PC; sequences core reset/run/drain/halt and records traps.
// Latency: all outputs registered (one cycle from inputs); no backpressure, the core is stepped every RUN cycle.
module pc_sequencer #(
  parameter int                    DATA_WIDTH      = pc_sequencer_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC        = '0,
  parameter int                    CORE_RST_CYCLES = 2,
  parameter int                    DRAIN_CYCLES    = 3,
  parameter int                    WDOG_CYCLES     = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] new_pc_i,
  input  logic [7:0]            exceptions_i,
  input  logic                  run_i,
  input  logic                  halt_req_i,
  input  logic                  pc_load_i,
  input  logic [DATA_WIDTH-1:0] pc_load_val_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  core_rst_o,
  output logic [1:0]            state_o,
  output logic                  halted_o,
  output logic [7:0]            cause_o,
  output logic [DATA_WIDTH-1:0] trap_pc_o,
  output logic [63:0]           cycle_cnt_o
);
  import pc_sequencer_pkg::*;

  localparam logic [2:0] ST_RESET = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  localparam int            RW         = cnt_width(CORE_RST_CYCLES);
  localparam int            DW         = cnt_width(DRAIN_CYCLES);
  localparam logic [RW-1:0] RST_LAST   = RW'(CORE_RST_CYCLES - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  logic [2:0]            state_q;
  logic [RW-1:0]         rst_cnt_q;
  logic [DW-1:0]         drain_cnt_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] trap_pc_q;
  logic [7:0]            cause_q;
  logic [63:0]           cycle_cnt_q;

  logic       in_run;
  logic       wdog_fire;
  logic       trap;
  logic [7:0] cause_nxt;
  logic       unused_exc;

  assign unused_exc = ^exceptions_i[7:5];
  assign in_run     = (state_q == ST_RUN);
  assign trap       = in_run && ((|exceptions_i[4:0]) || halt_req_i || wdog_fire);

  // Sources are ORed, not prioritised: every cause active in the capture cycle is kept.
  always_comb begin
    cause_nxt                            = '0;
    cause_nxt[CAUSE_EBREAK:CAUSE_FETCH]  = exceptions_i[CAUSE_EBREAK:CAUSE_FETCH];
    cause_nxt[CAUSE_HALT]                = halt_req_i;
    cause_nxt[CAUSE_WDOG]                = wdog_fire;
  end

  pc_watchdog #(
    .DATA_WIDTH  (DATA_WIDTH),
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (in_run),
    .clr_i    (!in_run || trap),
    .pc_i     (pc_q),
    .new_pc_i (new_pc_i),
    .fire_o   (wdog_fire)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_RESET;
      rst_cnt_q   <= '0;
      drain_cnt_q <= '0;
      pc_q        <= RESET_PC;
      trap_pc_q   <= '0;
      cause_q     <= '0;
      cycle_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (rst_cnt_q == RST_LAST) begin
            state_q <= ST_IDLE;
          end else begin
            rst_cnt_q <= rst_cnt_q + RW'(1);
          end
        end
        ST_IDLE, ST_HALT: begin
          if (pc_load_i) begin
            pc_q <= pc_load_val_i;
          end
          if (run_i) begin
            state_q <= ST_RUN;
            cause_q <= '0;
          end
        end
        ST_RUN: begin
          pc_q        <= new_pc_i;
          cycle_cnt_q <= cycle_cnt_q + 64'd1;
          if (trap) begin
            cause_q     <= cause_nxt;
            trap_pc_q   <= pc_q;
            drain_cnt_q <= '0;
            state_q     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_q == DRAIN_LAST) begin
            state_q <= ST_HALT;
          end else begin
            drain_cnt_q <= drain_cnt_q + DW'(1);
          end
        end
        default: state_q <= ST_RESET;
      endcase
    end
  end

  always_comb begin
    state_o = SEQ_RESET;
    case (state_q)
      ST_IDLE:           state_o = SEQ_IDLE;
      ST_RUN, ST_DRAIN:  state_o = SEQ_RUN;
      ST_HALT:           state_o = SEQ_HALT;
      default:           state_o = SEQ_RESET;
    endcase
  end

  assign pc_o        = pc_q;
  assign core_rst_o  = (state_q != ST_RUN) && (state_q != ST_DRAIN);
  assign halted_o    = (state_q == ST_HALT);
  assign cause_o     = cause_q;
  assign trap_pc_o   = trap_pc_q;
  assign cycle_cnt_o = cycle_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, run, ecall/halt traps, watchdog, load+run, reset mid-drain.
module tb_pc_sequencer;

  logic        clk_i;
  logic        rst_ni;
  logic [63:0] new_pc_i;
  logic [7:0]  exceptions_i;
  logic        run_i;
  logic        halt_req_i;
  logic        pc_load_i;
  logic [63:0] pc_load_val_i;
  logic [63:0] pc_o;
  logic        core_rst_o;
  logic [1:0]  state_o;
  logic        halted_o;
  logic [7:0]  cause_o;
  logic [63:0] trap_pc_o;
  logic [63:0] cycle_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer #(
    .DATA_WIDTH      (64),
    .RESET_PC        (64'h0),
    .CORE_RST_CYCLES (2),
    .DRAIN_CYCLES    (3),
    .WDOG_CYCLES     (8)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .new_pc_i      (new_pc_i),
    .exceptions_i  (exceptions_i),
    .run_i         (run_i),
    .halt_req_i    (halt_req_i),
    .pc_load_i     (pc_load_i),
    .pc_load_val_i (pc_load_val_i),
    .pc_o          (pc_o),
    .core_rst_o    (core_rst_o),
    .state_o       (state_o),
    .halted_o      (halted_o),
    .cause_o       (cause_o),
    .trap_pc_o     (trap_pc_o),
    .cycle_cnt_o   (cycle_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni        = 1'b0;
    new_pc_i      = 64'h0;
    exceptions_i  = 8'h00;
    run_i         = 1'b0;
    halt_req_i    = 1'b0;
    pc_load_i     = 1'b0;
    pc_load_val_i = 64'h0;

    // Reset state
    step();
    check("rst_state",   state_o,     2'd0);
    check("rst_pc",      pc_o,        64'h0);
    check("rst_core",    core_rst_o,  1'b1);
    check("rst_halted",  halted_o,    1'b0);
    check("rst_cause",   cause_o,     8'h00);
    check("rst_trappc",  trap_pc_o,   64'h0);
    check("rst_cnt",     cycle_cnt_o, 64'h0);

    // Release: two RESET cycles, inputs ignored, then IDLE
    rst_ni = 1'b1;
    run_i = 1'b1; pc_load_i = 1'b1; pc_load_val_i = 64'h300; halt_req_i = 1'b1;
    step();
    check("rel1_state", state_o,    2'd0);
    check("rel1_core",  core_rst_o, 1'b1);
    check("rel1_pc",    pc_o,       64'h0);
    run_i = 1'b0; pc_load_i = 1'b0; halt_req_i = 1'b0;
    step();
    check("idle_state", state_o,    2'd1);
    check("idle_pc",    pc_o,       64'h0);
    check("idle_core",  core_rst_o, 1'b1);

    // Run: pc 0,4,8 then cycle count 3
    run_i = 1'b1; new_pc_i = 64'h4;
    step();
    run_i = 1'b0;
    check("run_state", state_o,    2'd2);
    check("run_core",  core_rst_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("run_pc", pc_o, 64'(i * 4));
      new_pc_i = 64'((i + 1) * 4);
      step();
    end
    check("run_cnt3", cycle_cnt_o, 64'd3);
    check("run_pc12", pc_o,        64'hC);

    // Ecall at pc 0x40
    new_pc_i = 64'h40;
    step();
    check("pc40", pc_o, 64'h40);
    exceptions_i = 8'h08; new_pc_i = 64'h44;
    step();
    exceptions_i = 8'h00; new_pc_i = 64'h80;
    check("ecall_cause",  cause_o,   8'h08);
    check("ecall_trappc", trap_pc_o, 64'h40);
    for (int d = 0; d < 3; d++) begin
      check("drain_state",  state_o,     2'd2);
      check("drain_pc",     pc_o,        64'h44);
      check("drain_core",   core_rst_o,  1'b0);
      check("drain_halted", halted_o,    1'b0);
      check("drain_cnt",    cycle_cnt_o, 64'd5);
      step();
    end
    check("halt_state",  state_o,    2'd3);
    check("halt_halted", halted_o,   1'b1);
    check("halt_core",   core_rst_o, 1'b1);
    check("halt_cause",  cause_o,    8'h08);

    // Resume, then simultaneous decode fault + halt request
    run_i = 1'b1;
    step();
    run_i = 1'b0;
    check("resume_cause",  cause_o,   8'h00);
    check("resume_trappc", trap_pc_o, 64'h40);
    check("resume_pc",     pc_o,      64'h44);
    exceptions_i = 8'h02; halt_req_i = 1'b1; new_pc_i = 64'h48;
    step();
    check("dual_cause",  cause_o,   8'h22);
    check("dual_trappc", trap_pc_o, 64'h44);
    exceptions_i = 8'h10; halt_req_i = 1'b0;
    step();
    exceptions_i = 8'h00;
    check("drain_ebreak_cause", cause_o, 8'h22);
    step();
    step();
    check("dual_halt", halted_o, 1'b1);

    // Watchdog: stall at 0x100, progress on cycle 5, then 8 stalls
    pc_load_i = 1'b1; pc_load_val_i = 64'h100;
    step();
    pc_load_i = 1'b0;
    check("load_pc",    pc_o,    64'h100);
    check("load_state", state_o, 2'd3);
    run_i = 1'b1;
    step();
    run_i = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      check("wdog_quiet", cause_o, 8'h00);
      new_pc_i = (c == 5) ? 64'h104 : 64'h100;
      step();
    end
    check("wdog_cause",  cause_o,     8'h80);
    check("wdog_trappc", trap_pc_o,   64'h100);
    check("wdog_cnt",    cycle_cnt_o, 64'd20);
    step(); step(); step();
    check("wdog_halt", halted_o, 1'b1);

    // Load and run in the same cycle from HALT
    pc_load_i = 1'b1; pc_load_val_i = 64'h200; run_i = 1'b1; new_pc_i = 64'h999;
    step();
    pc_load_i = 1'b0; run_i = 1'b0;
    check("ldrun_pc",     pc_o,       64'h200);
    check("ldrun_state",  state_o,    2'd2);
    check("ldrun_cause",  cause_o,    8'h00);
    check("ldrun_core",   core_rst_o, 1'b0);
    check("ldrun_trappc", trap_pc_o,  64'h100);

    // Reset in the middle of DRAIN
    halt_req_i = 1'b1; new_pc_i = 64'h204;
    step();
    halt_req_i = 1'b0;
    check("hreq_cause", cause_o, 8'h20);
    step();
    rst_ni = 1'b0;
    step();
    check("mid_rst_state",  state_o,     2'd0);
    check("mid_rst_pc",     pc_o,        64'h0);
    check("mid_rst_core",   core_rst_o,  1'b1);
    check("mid_rst_halted", halted_o,    1'b0);
    check("mid_rst_cause",  cause_o,     8'h00);
    check("mid_rst_trappc", trap_pc_o,   64'h0);
    check("mid_rst_cnt",    cycle_cnt_o, 64'h0);
    rst_ni = 1'b1;
    step();
    check("mid_rel_halted", halted_o, 1'b0);
    step();
    check("mid_rel_state", state_o, 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
